// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC register and next-PC sequencer (optional counters: PCSEQ_PERF_EN)
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              halt,
    input  logic              id_jump,
    input  logic [31:0]       id_target,
    input  logic              ex_branch,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              if_valid,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              halted
`ifdef PCSEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_branch,
    output logic [CNT_W-1:0]  perf_mispred,
    output logic [CNT_W-1:0]  perf_jump
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;
    logic        w_jump_acc;
    logic        w_unused_bits;

    // Targets are word addresses; the low two bits are forced to zero.
    assign w_unused_bits = &{1'b0, id_target[1:0], ex_target[1:0]};

    assign w_pc_plus4 = r_pc + 32'd4;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        if_valid     = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        halted       = 1'b0;
        w_jump_acc   = 1'b0;
        case (r_state)
            S_BOOT: w_next_state = S_RUN;
            S_RUN: begin
                if_valid = 1'b1;
                // A taken branch is a misprediction and beats every other event.
                if (ex_branch && ex_taken) begin
                    w_next_pc  = {ex_target[31:2], 2'b00};
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (halt && !stall) begin
                    w_next_state = S_HALT;
                end else if (id_jump && !stall) begin
                    w_next_pc  = {id_target[31:2], 2'b00};
                    flush_ifid = 1'b1;
                    w_jump_acc = 1'b1;
                end else if (!stall) begin
                    w_next_pc = w_pc_plus4;
                end
            end
            S_HALT: halted = 1'b1;
            default: w_next_state = S_BOOT;
        endcase
    end

`ifdef PCSEQ_PERF_EN
    logic [CNT_W-1:0] r_perf_branch;
    logic [CNT_W-1:0] r_perf_mispred;
    logic [CNT_W-1:0] r_perf_jump;
    logic             w_run;

    assign w_run        = (r_state == S_RUN);
    assign perf_branch  = r_perf_branch;
    assign perf_mispred = r_perf_mispred;
    assign perf_jump    = r_perf_jump;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_branch  <= '0;
            r_perf_mispred <= '0;
            r_perf_jump    <= '0;
        end else begin
            if (w_run && ex_branch && (r_perf_branch != '1))
                r_perf_branch <= r_perf_branch + 1'b1;
            if (w_run && ex_branch && ex_taken && (r_perf_mispred != '1))
                r_perf_mispred <= r_perf_mispred + 1'b1;
            if (w_jump_acc && (r_perf_jump != '1))
                r_perf_jump <= r_perf_jump + 1'b1;
        end
    end
`else
    logic w_unused_cnt;
    assign w_unused_cnt = (CNT_W > 0) & w_jump_acc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer (PCSEQ_PERF_EN aware)
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall, halt, id_jump, ex_branch, ex_taken;
    logic [31:0] id_target, ex_target;
    logic [31:0] pc, pc_plus4;
    logic        if_valid, flush_ifid, flush_idex, halted;
`ifdef PCSEQ_PERF_EN
    logic [31:0] perf_branch, perf_mispred, perf_jump;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall      (stall),
        .halt       (halt),
        .id_jump    (id_jump),
        .id_target  (id_target),
        .ex_branch  (ex_branch),
        .ex_taken   (ex_taken),
        .ex_target  (ex_target),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .if_valid   (if_valid),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .halted     (halted)
`ifdef PCSEQ_PERF_EN
        ,
        .perf_branch  (perf_branch),
        .perf_mispred (perf_mispred),
        .perf_jump    (perf_jump)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall = 0; halt = 0; id_jump = 0; ex_branch = 0; ex_taken = 0;
        id_target = 32'h0; ex_target = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the sequencer in its first RUN cycle at pc=RESET_PC, at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rstn = 0;
        tick();
        rstn = 1;
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rstn = 0;
        #1;
        n_checks++;
        if (pc !== 32'h3000 || if_valid !== 1'b0 || flush_ifid !== 1'b0 ||
            flush_idex !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: pc=%h ifv=%b fi=%b fe=%b h=%b, want 3000 0 0 0 0",
                     pc, if_valid, flush_ifid, flush_idex, halted);
        end
        tick();
        rstn = 1;
        #1;
        n_checks++;
        if (pc !== 32'h3000 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_cycle: pc=%h ifv=%b, want 3000 0", pc, if_valid);
        end
        tick();
        n_checks++;
        if (pc !== 32'h3000 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_run: pc=%h ifv=%b, want 3000 1", pc, if_valid);
        end
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_checks++;
            if (pc !== 32'h3000 + 32'(4 * i) || if_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_fetch%0d: pc=%h ifv=%b, want %h 1", i, pc, if_valid,
                         32'h3000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        repeat (4) tick();
        n_checks++;
        if (pc !== 32'h3010) begin
            n_fail++;
            $display("FAIL bp_setup_pc: pc=%h, want 3010", pc);
        end
        ex_branch = 1; ex_taken = 1; ex_target = 32'h0000_3043;
        stall = 1; id_jump = 1; id_target = 32'h0000_5000;
        #1;
        n_checks++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_flush: fi=%b fe=%b, want 1 1", flush_ifid, flush_idex);
        end
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (pc !== 32'h3040 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_target: pc=%h fi=%b fe=%b, want 3040 0 0", pc, flush_ifid, flush_idex);
        end
    endtask

    task automatic test_jump_stall();
        do_reset();
        id_jump = 1; id_target = 32'h0000_3100; stall = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (pc !== 32'h3000 || flush_ifid !== 1'b0 || flush_idex !== 1'b0 || if_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL js_hold%0d: pc=%h fi=%b fe=%b ifv=%b, want 3000 0 0 1",
                         i, pc, flush_ifid, flush_idex, if_valid);
            end
            tick();
        end
        stall = 0;
        #1;
        n_checks++;
        if (pc !== 32'h3000 || flush_ifid !== 1'b1 || flush_idex !== 1'b0) begin
            n_fail++;
            $display("FAIL js_accept: pc=%h fi=%b fe=%b, want 3000 1 0", pc, flush_ifid, flush_idex);
        end
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (pc !== 32'h3100) begin
            n_fail++;
            $display("FAIL js_target: pc=%h, want 3100", pc);
        end
    endtask

    task automatic test_not_taken();
        do_reset();
        ex_branch = 1; ex_taken = 0; ex_target = 32'h0000_9000;
        #1;
        n_checks++;
        if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
            n_fail++;
            $display("FAIL nt_flush: fi=%b fe=%b, want 0 0", flush_ifid, flush_idex);
        end
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (pc !== 32'h3004) begin
            n_fail++;
            $display("FAIL nt_seq: pc=%h, want 3004", pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        id_jump = 1; id_target = 32'hFFFF_FFFE;
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pre: pc=%h p4=%h, want fffffffc 00000000", pc, pc_plus4);
        end
        tick();
        n_checks++;
        if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin
            n_fail++;
            $display("FAIL wrap_post: pc=%h p4=%h, want 00000000 00000004", pc, pc_plus4);
        end
    endtask

    task automatic test_halt();
        do_reset();
        halt = 1; ex_branch = 1; ex_taken = 1; ex_target = 32'h0000_3200;
        #1;
        n_checks++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_vs_branch: fi=%b fe=%b h=%b, want 1 1 0", flush_ifid, flush_idex, halted);
        end
        tick();
        clear_inputs();
        halt = 1;
        #1;
        n_checks++;
        if (pc !== 32'h3200 || halted !== 1'b0 || if_valid !== 1'b1 || flush_ifid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_accept: pc=%h h=%b ifv=%b fi=%b, want 3200 0 1 0", pc, halted, if_valid, flush_ifid);
        end
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            id_jump = 1; id_target = 32'h0000_7000;
            ex_branch = 1; ex_taken = 1; ex_target = 32'h0000_8000;
            #1;
            n_checks++;
            if (pc !== 32'h3200 || halted !== 1'b1 || if_valid !== 1'b0 ||
                flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_frozen%0d: pc=%h h=%b ifv=%b fi=%b fe=%b, want 3200 1 0 0 0",
                         i, pc, halted, if_valid, flush_ifid, flush_idex);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_redirect();
        do_reset();
        ex_branch = 1; ex_taken = 1; ex_target = 32'h0000_6000;
        #2;
        rstn = 0;
        #1;
        n_checks++;
        if (pc !== 32'h3000 || if_valid !== 1'b0 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: pc=%h ifv=%b fi=%b fe=%b, want 3000 0 0 0",
                     pc, if_valid, flush_ifid, flush_idex);
        end
        tick();
        clear_inputs();
        rstn = 1;
        tick();
        tick();
        n_checks++;
        if (pc !== 32'h3004) begin
            n_fail++;
            $display("FAIL mid_reset_resume: pc=%h, want 3004", pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_pc;
        bit          m_halted;
        bit          taken, exp_fi, exp_fe;
        do_reset();
        m_pc = 32'h3000;
        m_halted = 0;
        for (int i = 0; i < 400; i++) begin
            stall     = ($urandom_range(0, 3) == 0);
            halt      = ($urandom_range(0, 47) == 0);
            id_jump   = ($urandom_range(0, 4) == 0);
            ex_branch = ($urandom_range(0, 3) == 0);
            ex_taken  = 1'($urandom_range(0, 1));
            id_target = $urandom;
            ex_target = $urandom;
            taken  = !m_halted && ex_branch && ex_taken;
            exp_fe = taken;
            exp_fi = taken || (!m_halted && !taken && !(halt && !stall) && id_jump && !stall);
            #1;
            n_checks++;
            if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || if_valid !== !m_halted ||
                halted !== m_halted || flush_ifid !== exp_fi || flush_idex !== exp_fe) begin
                n_fail++;
                $display("FAIL rand%0d: pc=%h p4=%h ifv=%b h=%b fi=%b fe=%b, want %h %h %b %b %b %b",
                         i, pc, pc_plus4, if_valid, halted, flush_ifid, flush_idex,
                         m_pc, m_pc + 32'd4, !m_halted, m_halted, exp_fi, exp_fe);
            end
            if (!m_halted) begin
                if (taken)                  m_pc = ex_target & 32'hFFFF_FFFC;
                else if (halt && !stall)    m_halted = 1;
                else if (id_jump && !stall) m_pc = id_target & 32'hFFFF_FFFC;
                else if (!stall)            m_pc = m_pc + 32'd4;
            end
            tick();
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_reset();
                m_pc = 32'h3000;
                m_halted = 0;
            end
        end
        clear_inputs();
    endtask

`ifdef PCSEQ_PERF_EN
    task automatic test_perf();
        do_reset();
        ex_branch = 1; ex_taken = 1; ex_target = 32'h0000_3400;
        tick();
        ex_taken = 0;
        tick();
        ex_taken = 1; ex_target = 32'h0000_3500;
        tick();
        clear_inputs();
        id_jump = 1; id_target = 32'h0000_3600;
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (perf_branch !== 32'd3 || perf_mispred !== 32'd2 || perf_jump !== 32'd1) begin
            n_fail++;
            $display("FAIL perf_counts: br=%0d mp=%0d j=%0d, want 3 2 1", perf_branch, perf_mispred, perf_jump);
        end
        rstn = 0;
        #1;
        n_checks++;
        if (perf_branch !== 32'd0 || perf_mispred !== 32'd0 || perf_jump !== 32'd0 || pc !== 32'h3000) begin
            n_fail++;
            $display("FAIL perf_reset: br=%0d mp=%0d j=%0d pc=%h, want 0 0 0 3000",
                     perf_branch, perf_mispred, perf_jump, pc);
        end
        tick();
        rstn = 1;
        tick();
    endtask
`endif

    initial begin
        clear_inputs();
        rstn = 0;
        test_reset();
        test_branch_priority();
        test_jump_stall();
        test_not_taken();
        test_wrap();
        test_halt();
        test_reset_mid_redirect();
        test_random();
`ifdef PCSEQ_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch PC register and sequences the next-PC datapath each cycle. It selects between sequential fetch, ID-stage jump targets and EX-stage branch resolution.
- Fixed predict-not-taken policy. Generates IF/ID and ID/EX flush requests on redirects and handles pipeline stall and program halt.
- Sits between the next-PC logic (NPCOccur / NPCNotOccur / jump target outputs) and the instruction-memory address port.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address loaded on reset.
- CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- stall  input  1  hazard-unit stall; hold PC.
- halt  input  1  halt instruction decoded in ID.
- id_jump  input  1  j/jal/jr/jalr resolved in ID.
- id_target  input  32  jump target from next-PC logic.
- ex_branch  input  1  conditional branch in EX this cycle.
- ex_taken  input  1  branch condition true (qualified by ex_branch).
- ex_target  input  32  taken target (NPCOccur).
- pc  output  32  current fetch address.
- pc_plus4  output  32  pc + 4, wraps modulo 2^32.
- if_valid  output  1  fetch at pc is valid.
- flush_ifid  output  1  squash IF/ID register this cycle.
- flush_idex  output  1  squash ID/EX register this cycle.
- halted  output  1  sequencer is in HALT.

Behaviour:
- States: BOOT, RUN, HALT. The state register, pc and counters reset asynchronously when rstn=0.
- Reset values: pc=RESET_PC, state=BOOT, if_valid=0, flush_ifid=0, flush_idex=0, halted=0.
- BOOT: lasts exactly one cycle after rstn deasserts. pc is held, then the block moves to RUN. The first valid fetch is at RESET_PC.
- RUN: if_valid=1. Next pc is selected in strict priority order:
  1. ex_branch & ex_taken: pc <= {ex_target[31:2],2'b00}. flush_ifid=1 and flush_idex=1 in the same cycle. Overrides stall, id_jump and halt.
  2. halt & ~stall: enter HALT, pc held, no flush.
  3. id_jump & ~stall: pc <= {id_target[31:2],2'b00}. flush_ifid=1 (squash delay-slot fetch), flush_idex=0.
  4. stall: pc held, if_valid stays 1, no flush.
  5. otherwise: pc <= pc + 4. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- ex_branch with ex_taken=0 is the correct prediction: no flush, normal priority applies.
- Flush outputs are combinational from the current state and inputs. They are 0 outside RUN.
- HALT: pc frozen, if_valid=0, halted=1, all inputs ignored. The state is sticky until rstn=0.
- A reset asserted mid-operation, including mid-redirect, immediately forces the reset values. No pending redirect survives.
- One-cycle latency: a redirect input in cycle n puts the new pc on the pc output in cycle n+1.

Optional Feature:
- Macro: PCSEQ_PERF_EN.
- When defined, adds three outputs, each CNT_W bits: perf_branch, perf_mispred, perf_jump.
  - perf_branch increments on each RUN cycle with ex_branch=1.
  - perf_mispred increments on each RUN cycle with ex_branch&ex_taken.
  - perf_jump increments on each accepted id_jump (priority 3 taken).
  - All three saturate at all-ones and reset to 0.
- When undefined, these ports and registers do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset release, no other inputs -> pc=0x3000 for 2 cycles (BOOT, then first RUN), then 0x3004, 0x3008; if_valid rises one cycle after rstn.
- In RUN at pc=0x3010: ex_branch=1, ex_taken=1, ex_target=0x3040, stall=1, id_jump=1 -> flush_ifid=flush_idex=1 that cycle; next pc=0x3040.
- id_jump=1, id_target=0x3100 with stall=1 for 2 cycles, then stall=0 -> pc held 2 cycles, no flush; then flush_ifid=1 and pc=0x3100.
- pc=0xFFFF_FFFC, no events -> next pc=0x0000_0000, pc_plus4 wraps likewise.
- halt=1 with ex_branch=ex_taken=1 at once -> redirect wins, no HALT; halt=1 next cycle alone -> halted=1, if_valid=0, pc frozen despite id_jump pulses.
- With PCSEQ_PERF_EN: 3 branches (2 taken) and 1 jump -> perf_branch=3, perf_mispred=2, perf_jump=1; rstn pulse mid-run -> all counters 0, pc=0x3000.
